edge_relax: RTL and testbench

EDGE_RELAX -- requirements
Module: edge_relax

---
 rtl/pf_pkg.sv | 31 +++
 rtl/edge_relax_if.sv | 67 ++++++
 rtl/relax_cmp.sv | 30 +++
 rtl/edge_relax.sv | 181 ++++++++++++++++++
 tb/tb_edge_relax.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pf_pkg.sv
// Shared path-finding definitions used by edge_relax and priority_queue.
//   - pf_state_t : edge-relaxation FSM state encoding
//   - DIST_INF   : distance-table code for an unreached vertex
//   - *_FIELD    : field positions inside the 2*VERT_W-bit row-pointer and
//                  edge words; the field LSB is FIELD * VERT_W, so the same
//                  constants serve any vertex width.
package pf_pkg;

    localparam int unsigned PF_VERT_W = 16;

    localparam logic [15:0] DIST_INF = 16'hFFFF;

    // row-pointer word: {first_edge, end_edge}
    localparam int unsigned RP_FIRST_FIELD = 1;
    localparam int unsigned RP_END_FIELD   = 0;

    // edge word: {neighbor, weight}
    localparam int unsigned EDGE_NBR_FIELD = 1;
    localparam int unsigned EDGE_WT_FIELD  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_PTR,
        ST_RD_EDGE,
        ST_RD_DIST,
        ST_CMP,
        ST_PUSH,
        ST_DONE
    } pf_state_t;

endpackage

// File: rtl/edge_relax_if.sv
// Bus bundle between the edge-relaxation engine and its environment
// (pop side of the priority queue, row-pointer / edge / distance memories
// and the push side of the priority queue).
//   master : the relaxation engine
//   slave  : the environment (queue + memories)
// All read data returns one cycle after the address is presented.
interface edge_relax_if
    import pf_pkg::*;
#(
    parameter int unsigned VERT_W = PF_VERT_W
);

    // pop side
    logic                  start;
    logic [VERT_W-1:0]     pop_vertex;
    logic [VERT_W-1:0]     pop_dist;
    logic                  busy;
    logic                  done;

    // row-pointer table
    logic [VERT_W-1:0]     rp_addr;
    logic [2*VERT_W-1:0]   rp_rdata;

    // edge memory
    logic [VERT_W-1:0]     edge_addr;
    logic [2*VERT_W-1:0]   edge_rdata;

    // distance table
    logic [VERT_W-1:0]     dist_addr;
    logic [VERT_W-1:0]     dist_rdata;
    logic                  dist_we;
    logic [VERT_W-1:0]     dist_wdata;

    // push side
    logic                  push_en;
    logic [VERT_W-1:0]     push_vertex;
    logic [VERT_W-1:0]     push_prev_vertex;
    logic [VERT_W-1:0]     push_dist;
    logic                  push_ready;

    modport master (
        input  start, pop_vertex, pop_dist,
        output busy, done,
        output rp_addr,
        input  rp_rdata,
        output edge_addr,
        input  edge_rdata,
        output dist_addr, dist_we, dist_wdata,
        input  dist_rdata,
        output push_en, push_vertex, push_prev_vertex, push_dist,
        input  push_ready
    );

    modport slave (
        output start, pop_vertex, pop_dist,
        input  busy, done,
        input  rp_addr,
        output rp_rdata,
        input  edge_addr,
        output edge_rdata,
        input  dist_addr, dist_we, dist_wdata,
        output dist_rdata,
        input  push_en, push_vertex, push_prev_vertex, push_dist,
        output push_ready
    );

endinterface

// File: rtl/relax_cmp.sv
// Candidate-distance datapath for one edge.
//   base     in  settled distance of the popped vertex
//   weight   in  edge weight
//   cur_dist in  distance currently stored for the neighbor
//   cand     out base + weight, clamped to DIST_INF-1
//   relax    out cand strictly below cur_dist
// Clamping below DIST_INF keeps a reached vertex distinguishable from an
// unreached one, and makes a saturated candidate still relax an INF entry.
module relax_cmp
    import pf_pkg::*;
#(
    parameter int unsigned        VERT_W   = PF_VERT_W,
    parameter logic [VERT_W-1:0]  DIST_INF = pf_pkg::DIST_INF
) (
    input  logic [VERT_W-1:0] base,
    input  logic [VERT_W-1:0] weight,
    input  logic [VERT_W-1:0] cur_dist,
    output logic [VERT_W-1:0] cand,
    output logic              relax
);

    localparam logic [VERT_W-1:0] SAT_MAX = DIST_INF - VERT_W'(1);

    logic [VERT_W:0] sum;

    assign sum   = {1'b0, base} + {1'b0, weight};
    assign cand  = (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[VERT_W-1:0];
    assign relax = (cand < cur_dist);

endmodule

// File: rtl/edge_relax.sv
// Edge-relaxation engine: for a vertex popped from the priority queue, walk
// its adjacency list, compute a candidate distance per edge, and where it
// improves the stored distance write it back and push the neighbor.
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   bus    master side of edge_relax_if (pop, memories, push)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; rp_addr loaded on accept
// ST_RD_PTR  | row pointer on rp_rdata; empty list -> DONE
// ST_RD_EDGE | edge word on edge_rdata; neighbor becomes dist_addr
// ST_RD_DIST | neighbor distance on dist_rdata; candidate evaluated
// ST_CMP     | dist_we pulses here when the edge relaxes
// ST_PUSH    | push_en held with stable payload until push_ready
// ST_DONE    | done pulse, busy low, back to IDLE
//
// The compare result is registered at the end of RD_DIST so that the
// write-back pulse lines up with the CMP cycle itself.
module edge_relax
    import pf_pkg::*;
#(
    parameter int unsigned        VERT_W   = PF_VERT_W,
    parameter logic [VERT_W-1:0]  DIST_INF = pf_pkg::DIST_INF
) (
    input  logic        clk,
    input  logic        reset,
    edge_relax_if.master bus
);

    pf_state_t         state;

    logic [VERT_W-1:0] vtx_q;
    logic [VERT_W-1:0] base_q;
    logic [VERT_W-1:0] idx_q;
    logic [VERT_W-1:0] end_q;
    logic [VERT_W-1:0] nbr_q;
    logic [VERT_W-1:0] wt_q;
    logic [VERT_W-1:0] cand_q;
    logic              relax_q;

    logic [VERT_W-1:0] rp_first;
    logic [VERT_W-1:0] rp_end;
    logic [VERT_W-1:0] e_nbr;
    logic [VERT_W-1:0] e_wt;
    logic [VERT_W-1:0] idx_next;
    logic [VERT_W-1:0] cand_c;
    logic              relax_c;

    assign rp_first = bus.rp_rdata[RP_FIRST_FIELD * VERT_W +: VERT_W];
    assign rp_end   = bus.rp_rdata[RP_END_FIELD   * VERT_W +: VERT_W];
    assign e_nbr    = bus.edge_rdata[EDGE_NBR_FIELD * VERT_W +: VERT_W];
    assign e_wt     = bus.edge_rdata[EDGE_WT_FIELD  * VERT_W +: VERT_W];

    // Wraps at 16 bits; RD_PTR already rejected first >= end, so the walk
    // reaches end_q exactly without passing through a wrap.
    assign idx_next = idx_q + VERT_W'(1);

    relax_cmp #(
        .VERT_W   (VERT_W),
        .DIST_INF (DIST_INF)
    ) u_relax_cmp (
        .base     (base_q),
        .weight   (wt_q),
        .cur_dist (bus.dist_rdata),
        .cand     (cand_c),
        .relax    (relax_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            vtx_q                <= '0;
            base_q               <= '0;
            idx_q                <= '0;
            end_q                <= '0;
            nbr_q                <= '0;
            wt_q                 <= '0;
            cand_q               <= '0;
            relax_q              <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.rp_addr          <= '0;
            bus.edge_addr        <= '0;
            bus.dist_addr        <= '0;
            bus.dist_we          <= 1'b0;
            bus.dist_wdata       <= '0;
            bus.push_en          <= 1'b0;
            bus.push_vertex      <= '0;
            bus.push_prev_vertex <= '0;
            bus.push_dist        <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.dist_we <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        vtx_q       <= bus.pop_vertex;
                        base_q      <= bus.pop_dist;
                        bus.rp_addr <= bus.pop_vertex;
                        bus.busy    <= 1'b1;
                        state       <= ST_RD_PTR;
                    end
                end

                ST_RD_PTR: begin
                    idx_q <= rp_first;
                    end_q <= rp_end;
                    if (rp_first >= rp_end) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        bus.edge_addr <= rp_first;
                        state         <= ST_RD_EDGE;
                    end
                end

                ST_RD_EDGE: begin
                    nbr_q         <= e_nbr;
                    wt_q          <= e_wt;
                    bus.dist_addr <= e_nbr;
                    state         <= ST_RD_DIST;
                end

                ST_RD_DIST: begin
                    cand_q  <= cand_c;
                    relax_q <= relax_c;
                    if (relax_c) begin
                        bus.dist_we    <= 1'b1;
                        bus.dist_wdata <= cand_c;
                    end
                    state <= ST_CMP;
                end

                ST_CMP: begin
                    if (relax_q) begin
                        bus.push_en          <= 1'b1;
                        bus.push_vertex      <= nbr_q;
                        bus.push_prev_vertex <= vtx_q;
                        bus.push_dist        <= cand_q;
                        state                <= ST_PUSH;
                    end else if (idx_next == end_q) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        idx_q         <= idx_next;
                        bus.edge_addr <= idx_next;
                        state         <= ST_RD_EDGE;
                    end
                end

                ST_PUSH: begin
                    if (bus.push_ready) begin
                        bus.push_en <= 1'b0;
                        if (idx_next == end_q) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            idx_q         <= idx_next;
                            bus.edge_addr <= idx_next;
                            state         <= ST_RD_EDGE;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_relax.sv
module tb_edge_relax;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    edge_relax_if #(.VERT_W(16)) bus ();

    edge_relax #(
        .VERT_W   (16),
        .DIST_INF (16'hFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // environment memories (combinational read of the registered address)
    bit [31:0]   rp_mem    [0:65535];
    bit [31:0]   edge_mem  [0:65535];
    bit [15:0]   dist_init [0:65535];
    int unsigned write_gen [0:65535];
    bit [15:0]   wr_val    [0:65535];
    int unsigned cur_gen = 1;

    assign bus.rp_rdata   = rp_mem[bus.rp_addr];
    assign bus.edge_rdata = edge_mem[bus.edge_addr];
    assign bus.dist_rdata = (write_gen[bus.dist_addr] == cur_gen) ?
                            wr_val[bus.dist_addr] : dist_init[bus.dist_addr];

    bit [31:0] wr_log   [$];
    bit [47:0] push_log [$];

    always @(negedge clk) begin
        if (bus.dist_we) begin
            wr_log.push_back({bus.dist_addr, bus.dist_wdata});
            write_gen[bus.dist_addr] <= cur_gen;
            wr_val[bus.dist_addr]    <= bus.dist_wdata;
        end
        if (bus.push_en && bus.push_ready)
            push_log.push_back({bus.push_vertex, bus.push_prev_vertex, bus.push_dist});
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, 64'({bus.busy, bus.done, bus.push_en, bus.dist_we}), 64'd0);
        check({tag, "_addr"}, 64'({bus.rp_addr, bus.edge_addr, bus.dist_addr}), 64'd0);
        check({tag, "_data"}, {bus.dist_wdata, bus.push_vertex, bus.push_prev_vertex, bus.push_dist}, 64'd0);
    endtask

    // Reference: walk the adjacency list with plain arithmetic, tracking
    // distances updated earlier in the same list, then run the DUT and
    // compare writes, pushes, payload stability, busy and latency.
    task automatic run_case(input string tag, input bit [15:0] pv, input bit [15:0] pd, input int wait_c);
        bit [15:0] first, last, n, w, dc, cand;
        bit [16:0] s;
        bit [15:0] md [int];
        bit [31:0] exp_w [$];
        bit [47:0] exp_p [$];
        int exp_lat, lat, wb, pb, hold, idx;
        bit seen;

        first   = rp_mem[pv][31:16];
        last    = rp_mem[pv][15:0];
        exp_lat = 3;
        for (int i = int'(first); i < int'(last); i++) begin
            n  = edge_mem[i][31:16];
            w  = edge_mem[i][15:0];
            dc = md.exists(int'(n)) ? md[int'(n)] : dist_init[n];
            s  = 17'(pd) + 17'(w);
            cand = (s > 17'h0FFFE) ? 16'hFFFE : s[15:0];
            if (cand < dc) begin
                exp_w.push_back({n, cand});
                exp_p.push_back({n, pv, cand});
                md[int'(n)] = cand;
                exp_lat += 4 + wait_c;
            end else begin
                exp_lat += 3;
            end
        end

        cur_gen++;
        wb = wr_log.size();
        pb = push_log.size();

        @(posedge clk); #1;
        bus.pop_vertex = pv;
        bus.pop_dist   = pd;
        bus.start      = 1'b1;
        lat  = 1;
        hold = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
            if (bus.done) begin
                seen = 1'b1;
                bus.push_ready = 1'b0;
            end else begin
                check({tag, "_busy"}, 64'(bus.busy), 64'd1);
                if (bus.push_en) begin
                    idx = push_log.size() - pb;
                    if (idx < exp_p.size())
                        check({tag, "_push_payload"},
                              64'({bus.push_vertex, bus.push_prev_vertex, bus.push_dist}),
                              64'(exp_p[idx]));
                    else
                        check({tag, "_unexpected_push_en"}, 64'(bus.push_en), 64'd0);
                    bus.push_ready = (hold >= wait_c);
                    hold++;
                end else begin
                    bus.push_ready = 1'b0;
                    hold = 0;
                end
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_n_writes"}, 64'(wr_log.size() - wb), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && (wb + k) < wr_log.size(); k++)
            check({tag, "_write"}, 64'(wr_log[wb + k]), 64'(exp_w[k]));
        check({tag, "_n_pushes"}, 64'(push_log.size() - pb), 64'(exp_p.size()));
        for (int k = 0; k < exp_p.size() && (pb + k) < push_log.size(); k++)
            check({tag, "_push"}, 64'(push_log[pb + k]), 64'(exp_p[k]));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    endtask

    bit seen_push;
    int pb_rst;

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.pop_vertex = '0;
        bus.pop_dist   = '0;
        bus.push_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;

        // empty list, first == end
        rp_mem[4] = {16'd5, 16'd5};
        run_case("empty", 16'd4, 16'd100, 0);

        // empty list, end_edge = 0 with first_edge > 0 (no wrap)
        rp_mem[6] = {16'd9, 16'd0};
        run_case("empty_end0", 16'd6, 16'd50, 0);

        // single relax
        rp_mem[2]    = {16'd20, 16'd21};
        edge_mem[20] = {16'd7, 16'd3};
        dist_init[7] = 16'hFFFF;
        run_case("single_relax", 16'd2, 16'd10, 0);

        // equal candidate does not relax
        dist_init[7] = 16'd13;
        run_case("no_relax", 16'd2, 16'd10, 0);

        // backpressure: ready low 4 cycles
        dist_init[7] = 16'hFFFF;
        run_case("backpressure", 16'd2, 16'd10, 4);

        // saturation
        rp_mem[3]    = {16'd30, 16'd31};
        edge_mem[30] = {16'd8, 16'h0020};
        dist_init[8] = 16'hFFFF;
        run_case("saturate", 16'd3, 16'hFFF0, 0);

        // zero-weight self loop
        rp_mem[5]    = {16'd40, 16'd41};
        edge_mem[40] = {16'd5, 16'd0};
        dist_init[5] = 16'd20;
        run_case("self_loop", 16'd5, 16'd20, 0);

        // reset while a push is pending
        dist_init[7] = 16'hFFFF;
        cur_gen++;
        pb_rst = push_log.size();
        @(posedge clk); #1;
        bus.pop_vertex = 16'd2;
        bus.pop_dist   = 16'd10;
        bus.start      = 1'b1;
        bus.push_ready = 1'b0;
        seen_push      = 1'b0;
        for (int c = 0; c < 20 && !seen_push; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.push_en) seen_push = 1'b1;
        end
        check("rst_push_reached", 64'(seen_push), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero_outputs("rst_mid_push");
        check("rst_push_dropped", 64'(push_log.size() - pb_rst), 64'd0);
        run_case("after_rst", 16'd2, 16'd10, 1);

        // randomized adjacency lists
        for (int k = 0; k < 30; k++) begin
            bit [15:0] pv, pd, f;
            int ne;
            pv = 16'($urandom_range(0, 63));
            f  = 16'(100 + 8 * k);
            ne = int'($urandom_range(0, 5));
            rp_mem[pv] = {f, f + 16'(ne)};
            for (int j = 0; j < ne; j++)
                edge_mem[int'(f) + j] = {16'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF))
                                                : 16'($urandom_range(0, 40))};
            for (int j = 0; j < 16; j++)
                dist_init[j] = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 80));
            pd = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF))
                                             : 16'($urandom_range(0, 50));
            run_case("rand", pv, pd, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
